// File: rtl/control_unit_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_pkg
// Shared constants and types for the simple microprocessor sequencer:
// instruction/opcode/address widths, opcode encodings and FSM state encodings.
// -----------------------------------------------------------------------------
package control_unit_pkg;

    localparam int INST_WIDTH   = 21;  // opcode occupies bits [20:18]
    localparam int OPCODE_WIDTH = 3;
    localparam int ADDR_WIDTH   = 6;   // 64 instruction words

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_MOV  = 3'b110,  // passes Source_Reg1
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

endpackage

// File: rtl/control_unit_pc_counter.sv
// -----------------------------------------------------------------------------
// pc_counter
// Program counter: wrapping up-counter with increment enable.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (count -> 0)
//   inc   - advance by one on the next rising edge, wrapping 2^WIDTH-1 -> 0
//   count - current value
// -----------------------------------------------------------------------------
module pc_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;  // natural wrap at the counter width
        end
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Multi-cycle sequencer: FETCH -> LOAD -> DECODE -> [EXECUTE] -> WRITEBACK,
// stopping in HALT. Owns the PC, drives the RAM read request, the instruction
// register load strobe, register-file read/write strobes and the ALU function.
// All outputs are registered and track the state they belong to.
//
// Optional feature (macro CU_SINGLE_STEP_EN): adds the Step input; WRITEBACK
// only exits to FETCH on a cycle with Step=1. Without the macro the sequencer
// free-runs.
//
// Ports:
//   Clk, Reset_n    - clock, asynchronous active-low reset
//   Start           - leaves IDLE
//   Ram_Inst_Valid  - RAM word valid (sampled in FETCH only)
//   Opcode          - opcode from the instruction register (sampled in DECODE)
//   Step            - single-step advance (CU_SINGLE_STEP_EN only)
//   PC              - instruction address to RAM
//   Ram_Read        - instruction read request (FETCH)
//   IR_Load         - instruction register capture strobe (LOAD)
//   Reg_Read        - register-file read strobe (EXECUTE)
//   ALU_Op          - ALU function (EXECUTE, held through WRITEBACK)
//   Reg_Write       - register-file write strobe (first WRITEBACK cycle)
//   Halted          - processor stopped
// -----------------------------------------------------------------------------
module control_unit
    import control_unit_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Start,
    input  logic                    Ram_Inst_Valid,
    input  logic [OPCODE_WIDTH-1:0] Opcode,
`ifdef CU_SINGLE_STEP_EN
    input  logic                    Step,
`endif
    output logic [ADDR_WIDTH-1:0]   PC,
    output logic                    Ram_Read,
    output logic                    IR_Load,
    output logic                    Reg_Read,
    output logic [2:0]              ALU_Op,
    output logic                    Reg_Write,
    output logic                    Halted
);

    state_e  state;
    opcode_e op_q;        // opcode latched in DECODE
    logic    wb_advance;  // WRITEBACK may leave this cycle
    logic    pc_inc;

`ifdef CU_SINGLE_STEP_EN
    assign wb_advance = Step;
`else
    assign wb_advance = 1'b1;
`endif

    // PC moves only when WRITEBACK is actually left, so it stays stable
    // for the whole instruction.
    assign pc_inc = (state == ST_WRITEBACK) && wb_advance;

    pc_counter #(
        .WIDTH (ADDR_WIDTH)
    ) u_pc_counter (
        .clk   (Clk),
        .rst_n (Reset_n),
        .inc   (pc_inc),
        .count (PC)
    );

    // Outputs are assigned together with the state transition that enters
    // the state they belong to, so they are registered yet exactly Moore.
    // NOTE: every flop here, outputs included, is cleared by the async reset so
    // an instruction in flight is aborted immediately with no stray strobe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_NOP;
            Ram_Read  <= 1'b0;
            IR_Load   <= 1'b0;
            Reg_Read  <= 1'b0;
            ALU_Op    <= OP_NOP;
            Reg_Write <= 1'b0;
            Halted    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state    <= ST_FETCH;
                        Ram_Read <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (Ram_Inst_Valid) begin
                        state    <= ST_LOAD;
                        Ram_Read <= 1'b0;
                        IR_Load  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state   <= ST_DECODE;
                    IR_Load <= 1'b0;
                end
                ST_DECODE: begin
                    if (Opcode == OP_HALT) begin
                        state  <= ST_HALT;
                        Halted <= 1'b1;
                    end else begin
                        // NOP is latched too so WRITEBACK knows not to write.
                        op_q   <= opcode_e'(Opcode);
                        ALU_Op <= Opcode;
                        if (Opcode == OP_NOP) begin
                            state <= ST_WRITEBACK;
                        end else begin
                            state    <= ST_EXECUTE;
                            Reg_Read <= 1'b1;
                        end
                    end
                end
                ST_EXECUTE: begin
                    state     <= ST_WRITEBACK;
                    Reg_Read  <= 1'b0;
                    Reg_Write <= (op_q != OP_NOP);
                end
                ST_WRITEBACK: begin
                    // Write lasts one cycle even if single-step holds us here.
                    Reg_Write <= 1'b0;
                    if (wb_advance) begin
                        state    <= ST_FETCH;
                        ALU_Op   <= OP_NOP;
                        Ram_Read <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;  // only reset leaves
                end
                default: begin
                    state     <= ST_IDLE;
                    Ram_Read  <= 1'b0;
                    IR_Load   <= 1'b0;
                    Reg_Read  <= 1'b0;
                    ALU_Op    <= OP_NOP;
                    Reg_Write <= 1'b0;
                    Halted    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the simple microprocessor. Owns the program counter, requests instructions from RAM, pulses `IR_Load` so the instruction register captures them, then consumes the `Opcode` field the instruction register produces. It drives register-file read/write strobes and the ALU operation, and stops on HALT. It sits directly around the instruction register: upstream as its load controller, downstream as the consumer of its decoded opcode.

## Interface
- `OPCODE_WIDTH`, 3, opcode field width (bits [20:18] of the instruction)
- `ADDR_WIDTH`, 6, program-counter width (64 instruction words)
- `Clk` input 1: rising-edge clock
- `Reset_n` input 1: asynchronous, active-low reset
- `Start` input 1: leaves IDLE
- `Ram_Inst_Valid` input 1: RAM instruction word is valid on `Ram_Inst_Out`
- `Opcode` input OPCODE_WIDTH: opcode from the instruction register
- `Step` input 1: single-step advance; present only with `CU_SINGLE_STEP_EN`
- `PC` output ADDR_WIDTH: instruction address presented to RAM
- `Ram_Read` output 1: instruction read request
- `IR_Load` output 1: instruction-register capture strobe
- `Reg_Read` output 1: register-file read of Source_Reg1/Source_Reg2
- `ALU_Op` output 3: ALU function
- `Reg_Write` output 1: register-file write to Dest_Reg
- `Halted` output 1: processor stopped

## Operation
- Opcodes:
  - 000 NOP
  - 001 ADD
  - 010 SUB
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 MOV (passes Source_Reg1)
  - 111 HALT
- States: IDLE, FETCH, LOAD, DECODE, EXECUTE, WRITEBACK, HALT. Outputs are Moore, decoded from the registered state.
- IDLE → FETCH when `Start`=1. Otherwise stay in IDLE.
- FETCH: `Ram_Read`=1. Stay until `Ram_Inst_Valid`=1 is sampled, then → LOAD.
- LOAD: `IR_Load`=1 for exactly one cycle. RAM holds `Ram_Inst_Out` stable through this cycle. → DECODE.
- DECODE: `Opcode` is sampled.
  - 111 → HALT.
  - 000 → WRITEBACK, skipping EXECUTE.
  - Otherwise → EXECUTE, and the opcode is latched into an internal register.
- EXECUTE: `Reg_Read`=1 and `ALU_Op`=latched opcode. → WRITEBACK.
- WRITEBACK:
  - `Reg_Write`=1 unless the latched opcode is NOP.
  - `ALU_Op` holds its value.
  - PC increments by 1 on exit, wrapping modulo 2^ADDR_WIDTH (63 → 0).
  - → FETCH.
- HALT: `Halted`=1. PC does not increment. Only reset exits this state; `Start` is ignored here.
- `Ram_Inst_Valid` is ignored outside FETCH.
- `Opcode` is ignored outside DECODE.
- Reset values: state IDLE; PC 0; latched opcode 000; all outputs 0.
- Reset asserted mid-instruction aborts it immediately. No write occurs after reset assertion.

## Timing
- Reset takes effect asynchronously. State advances on the first rising edge after `Reset_n` deasserts.
- Instruction latency with a single-cycle RAM response (valid sampled in the first FETCH cycle): 5 cycles for ALU/MOV (FETCH, LOAD, DECODE, EXECUTE, WRITEBACK); 4 cycles for NOP. Each additional RAM wait cycle adds one FETCH cycle.
- `IR_Load` is high for exactly one cycle per instruction. `Opcode` is valid in the cycle after LOAD.
- `Reg_Write` is high for exactly one cycle per writing instruction. `Reg_Read` is high for exactly one cycle.
- `PC` is stable from FETCH entry until WRITEBACK exit.
- `Halted` rises in the cycle after a DECODE of 111.

## Configuration
- `CU_SINGLE_STEP_EN`:
  - Defined: the `Step` port exists. WRITEBACK → FETCH happens only on a cycle with `Step`=1; otherwise the block waits in WRITEBACK with `Reg_Write` low after its first cycle, so the write is still exactly one cycle. The first fetch after `Start` needs no `Step`.
  - Undefined: no `Step` port; free-running behaviour as described above.

## Structure
- Opcode constants (OP_NOP to OP_HALT), state encodings, `INST_WIDTH`, `OPCODE_WIDTH` and `ADDR_WIDTH` live in the shared parameters include. Nothing in this list is local to the block.
- One sub-module, `pc_counter`: a wrapping counter with asynchronous active-low reset and increment enable.

## Test plan
- Reset, `Start`, RAM valid every cycle, program ADD;SUB;HALT → `IR_Load` pulses at cycles 2, 7 and 12; `Reg_Write` at cycles 5 and 10; `Halted`=1 at cycle 14; PC ends at 2.
- RAM valid delayed 3 cycles on every fetch → `Ram_Read` held high for 4 cycles per fetch; no `IR_Load` before valid.
- NOP stream of 64 words → PC wraps 63 → 0; `Reg_Write` never asserts; 4 cycles per instruction.
- `Reset_n` dropped during EXECUTE of XOR → all outputs 0 at once; no `Reg_Write`; PC=0.
- In HALT, pulse `Start` and `Ram_Inst_Valid` → state unchanged; `Halted` stays 1.
- With `CU_SINGLE_STEP_EN`: `Step` held low → the block stays in WRITEBACK with `Reg_Write` high for one cycle only; a `Step` pulse → next FETCH.
